// File: rtl/lc3_exec_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lc3_exec_pkg
//  Purpose  : Shared definitions for the LC-3 execution unit: ALU operation
//             codes, multiplier state encoding and the condition-code reset
//             value.
//  Revision : 1.0 - initial release
// ============================================================================
package lc3_exec_pkg;

    // ALU operation selects (driven on i_ALUK)
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_AND  = 3'b001;
    localparam logic [2:0] ALU_NOT  = 3'b010;
    localparam logic [2:0] ALU_PASS = 3'b011;
    localparam logic [2:0] ALU_MUL  = 3'b100;
    localparam logic [2:0] ALU_SHL  = 3'b101;
    localparam logic [2:0] ALU_SRA  = 3'b110;
    localparam logic [2:0] ALU_XOR  = 3'b111;

    // Sequential multiplier states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mul_state_t;

    // Condition codes come out of reset as Z
    localparam logic [2:0] c_NZP_RESET = 3'b010;

endpackage
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : seq_multiplier
//  Purpose  : Shift-add unsigned multiplier, one multiplier bit per cycle.
//             Returns the low DATA_W bits of A*B after DATA_W RUN cycles.
//  Ports    : i_CLK, i_RST (async, active-high)
//             i_Start  - start request, honoured only in IDLE
//             i_A/i_B  - operands, captured on the start edge
//             o_Busy   - high while in RUN
//             o_Done   - one-cycle pulse in DONE
//             o_Prod   - product, held until the next completion
//  Revision : 1.0 - initial release
// ============================================================================
module seq_multiplier
    import lc3_exec_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_Start,
    input  logic [DATA_W-1:0] i_A,
    input  logic [DATA_W-1:0] i_B,
    output logic              o_Busy,
    output logic              o_Done,
    output logic [DATA_W-1:0] o_Prod
);

    localparam int             CNT_W      = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(DATA_W - 1);

    mul_state_t        r_state;
    mul_state_t        w_state_next;
    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_prod;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] w_acc_next;
    logic              w_last;

    // Accumulator value after the current RUN step; on the last step this is
    // the finished product, so it is loaded into r_prod directly.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_last     = (r_cnt == c_LAST_CNT);

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_Busy       = 1'b0;
        o_Done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_Start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                o_Busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                o_Done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_prod   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_Start) begin
                        r_mcand  <= i_A;
                        r_mplier <= i_B;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_prod <= w_acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_Prod = r_prod;

endmodule
`default_nettype wire

// File: rtl/lc3_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : lc3_exec_unit
//  Purpose  : LC-3 execution unit: register file, operand selection,
//             extended ALU (with sequential multiply) and NZP register.
//  Ports    : i_CLK, i_RST (async, active-high)
//             i_LD_REG/i_DR_Addr/i_bus - register write from the bus
//             i_SR1_Addr/i_SR2_Addr    - source register selects
//             i_Imm_En/i_Imm           - immediate operand B (sign-extended)
//             i_ALUK                   - ALU operation
//             i_Start                  - start multiply
//             i_LD_CC                  - load NZP from the bus
//             o_SR1_Out                - SR1 read data
//             o_ToBus                  - ALU result
//             o_Busy/o_Done            - multiply status
//             o_N/o_Z/o_P              - condition codes
//  Revision : 1.0 - initial release
// ============================================================================
module lc3_exec_unit
    import lc3_exec_pkg::*;
#(
    parameter  int DATA_W   = 16,
    parameter  int NUM_REGS = 8,
    parameter  int IMM_W    = 5,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_LD_REG,
    input  logic [ADDR_W-1:0] i_DR_Addr,
    input  logic [ADDR_W-1:0] i_SR1_Addr,
    input  logic [ADDR_W-1:0] i_SR2_Addr,
    input  logic              i_Imm_En,
    input  logic [IMM_W-1:0]  i_Imm,
    input  logic [2:0]        i_ALUK,
    input  logic              i_Start,
    input  logic              i_LD_CC,
    input  logic [DATA_W-1:0] i_bus,
    output logic [DATA_W-1:0] o_SR1_Out,
    output logic [DATA_W-1:0] o_ToBus,
    output logic              o_Busy,
    output logic              o_Done,
    output logic              o_N,
    output logic              o_Z,
    output logic              o_P
);

    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [2:0]        r_nzp;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_sr2;
    logic [DATA_W-1:0] w_imm_sext;
    logic [DATA_W-1:0] w_op_b;
    logic [SH_W-1:0]   w_shamt;
    logic [DATA_W-1:0] w_prod;
    logic [DATA_W-1:0] w_alu;
    logic              w_bus_neg;
    logic              w_bus_zero;

    // ------------------------------------------------------------------
    // Register file: combinational reads, write lands at the clock edge
    // ------------------------------------------------------------------
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_LD_REG) begin
            r_regs[i_DR_Addr] <= i_bus;
        end
    end

    assign w_op_a     = r_regs[i_SR1_Addr];
    assign w_sr2      = r_regs[i_SR2_Addr];
    assign w_imm_sext = {{(DATA_W - IMM_W){i_Imm[IMM_W-1]}}, i_Imm};
    assign w_op_b     = i_Imm_En ? w_imm_sext : w_sr2;
    // Only the low bits of B form the shift amount, so it never reaches
    // DATA_W when DATA_W is a power of two.
    assign w_shamt    = w_op_b[SH_W-1:0];

    // ------------------------------------------------------------------
    // Multiplier: operands are captured on the start edge, so register
    // writes and address changes while it runs do not disturb it.
    // ------------------------------------------------------------------
    seq_multiplier #(
        .DATA_W (DATA_W)
    ) u_mul (
        .i_CLK   (i_CLK),
        .i_RST   (i_RST),
        .i_Start (i_Start),
        .i_A     (w_op_a),
        .i_B     (w_op_b),
        .o_Busy  (o_Busy),
        .o_Done  (o_Done),
        .o_Prod  (w_prod)
    );

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    always_comb begin
        w_alu = '0;
        case (i_ALUK)
            ALU_ADD:  w_alu = w_op_a + w_op_b;
            ALU_AND:  w_alu = w_op_a & w_op_b;
            ALU_NOT:  w_alu = ~w_op_a;
            ALU_PASS: w_alu = w_op_a;
            ALU_MUL:  w_alu = w_prod;
            ALU_SHL:  w_alu = w_op_a << w_shamt;
            ALU_SRA:  w_alu = DATA_W'($signed(w_op_a) >>> w_shamt);
            ALU_XOR:  w_alu = w_op_a ^ w_op_b;
            default:  w_alu = '0;
        endcase
    end

    assign o_ToBus   = w_alu;
    assign o_SR1_Out = w_op_a;

    // ------------------------------------------------------------------
    // Condition codes: always one-hot
    // ------------------------------------------------------------------
    assign w_bus_neg  = i_bus[DATA_W-1];
    assign w_bus_zero = (i_bus == '0);

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_nzp <= c_NZP_RESET;
        end else if (i_LD_CC) begin
            r_nzp <= {w_bus_neg, w_bus_zero, ~(w_bus_neg | w_bus_zero)};
        end
    end

    assign o_N = r_nzp[2];
    assign o_Z = r_nzp[1];
    assign o_P = r_nzp[0];

endmodule
`default_nettype wire
